// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, sync-region bounds and coordinate type
// for vga_timing and pixel_feeder.
`default_nettype none

package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Inclusive sync windows measured from the start of the line / frame
  localparam int HSYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int HSYNC_END_DEF   = HSYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int VSYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int VSYNC_END_DEF   = VSYNC_START_DEF + V_SYNC_DEF - 1;

  localparam int COORD_W = $clog2((H_TOTAL_DEF > V_TOTAL_DEF) ? H_TOTAL_DEF : V_TOTAL_DEF);

  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_span(input coord_t val, input coord_t lo, input coord_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wrap_counter.sv
// Modulo-MODULUS up-counter with synchronous clear; wrap_o strobes on the
// increment that returns the count to zero.
`default_nettype none

module wrap_counter #(
  parameter int WIDTH   = 10,
  parameter int MODULUS = 800
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] value_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  assign wrap_o  = inc_i && (value_q == LAST);
  assign value_o = value_q;

  always_comb begin
    value_d = value_q;
    if (inc_i) begin
      value_d = wrap_o ? '0 : value_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_timing.sv
// Free-running VGA timing generator with registered sync/active/event outputs.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
`default_nettype none

module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk_25,
  input  logic               rst_n,
  output logic               hsync,
  output logic               vsync,
  output logic               disp_active,
  output logic               line_end,
  output logic               frame_end,
  output logic [COORD_W-1:0] h_pos,
  output logic [COORD_W-1:0] v_pos
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [7:0]         frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
  localparam coord_t V_LAST_C = coord_t'(V_ACTIVE - 1);
  localparam coord_t HS_LO_C  = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_HI_C  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_LO_C  = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_HI_C  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic   cnt_clr;
  logic   h_wrap;
  logic   v_wrap_unused;
  coord_t h_cnt;
  coord_t v_cnt;

  assign cnt_clr = ~rst_n;

  wrap_counter #(
    .WIDTH   (COORD_W),
    .MODULUS (H_TOTAL)
  ) u_h_cnt (
    .clk_i   (clk_25),
    .clr_i   (cnt_clr),
    .inc_i   (1'b1),
    .value_o (h_cnt),
    .wrap_o  (h_wrap)
  );

  wrap_counter #(
    .WIDTH   (COORD_W),
    .MODULUS (V_TOTAL)
  ) u_v_cnt (
    .clk_i   (clk_25),
    .clr_i   (cnt_clr),
    .inc_i   (h_wrap),
    .value_o (v_cnt),
    .wrap_o  (v_wrap_unused)
  );

  logic   hsync_d, hsync_q;
  logic   vsync_d, vsync_q;
  logic   disp_d, disp_q;
  logic   line_end_d, line_end_q;
  logic   frame_end_d, frame_end_q;
  coord_t h_pos_q, v_pos_q;

  // Decode the current counter position; registered below so every output is glitch-free
  always_comb begin
    disp_d      = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    hsync_d     = in_span(h_cnt, HS_LO_C, HS_HI_C) ? SYNC_POL : ~SYNC_POL;
    vsync_d     = in_span(v_cnt, VS_LO_C, VS_HI_C) ? SYNC_POL : ~SYNC_POL;
    line_end_d  = (h_cnt == H_ACT_C) && (v_cnt < V_ACT_C);
    frame_end_d = (h_cnt == H_ACT_C) && (v_cnt == V_LAST_C);
  end

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      disp_q      <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      h_pos_q     <= '0;
      v_pos_q     <= '0;
    end else begin
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      disp_q      <= disp_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
      h_pos_q     <= h_cnt;
      v_pos_q     <= v_cnt;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign disp_active = disp_q;
  assign line_end    = line_end_q;
  assign frame_end   = frame_end_q;
  assign h_pos       = h_pos_q;
  assign v_pos       = v_pos_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  // Steps on the same edge that raises frame_end
  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      frame_cnt_q <= 8'd0;
    end else if (frame_end_d) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

`default_nettype wire
